// File: rtl/mtrap_cause_unit.sv
// Machine-mode trap-cause unit: prioritises exception/interrupt lines, holds the winner until
// the pipeline acks, then commits mcause/mepc/mtval. Optional mtval storage via MTRAP_MTVAL_EN.
module mtrap_cause_unit #(
    parameter int          XLEN        = 32,
    parameter int          NUM_EXC     = 16,
    parameter int          NUM_IRQ     = 16,
    parameter int          CODE_W      = 5,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_EXC-1:0]  exc_req_in,
    input  logic [NUM_IRQ-1:0]  irq_req_in,
    input  logic                mie_global_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     tval_in,
    input  logic                trap_ack_in,
    input  logic                mret_in,
    input  logic [11:0]         csr_addr_in,
    input  logic                wr_en_in,
    input  logic [XLEN-1:0]     data_wr_in,
    output logic [XLEN-1:0]     csr_rd_out,
    output logic                csr_hit_out,
    output logic [XLEN-1:0]     mcause_out,
    output logic [XLEN-1:0]     mepc_out,
    output logic [XLEN-1:0]     mtval_out,
    output logic [CODE_W-1:0]   cause_out,
    output logic                int_or_exc_out,
    output logic                trap_pending_out,
    output logic                trap_taken_out,
    output logic                in_handler_out
);

    typedef enum logic [1:0] {IDLE, PEND, HANDLER} state_t;

    localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t              state;
    state_t              state_next;
    logic                exc_any;
    logic                irq_take;
    logic                capture;
    logic                commit;
    logic [CODE_W-1:0]   exc_code;
    logic [CODE_W-1:0]   irq_code;
    logic                held_int;
    logic [CODE_W-1:0]   held_code;
    logic [XLEN-1:0]     held_pc;
    logic [XLEN-1:0]     trap_cause;
    logic [XLEN-1:0]     mcause;
    logic [XLEN-1:0]     mepc;
    logic                trap_taken;
    logic                wr_mcause;
    logic                wr_mepc;

    assign exc_any   = |exc_req_in;
    assign irq_take  = (|irq_req_in) & mie_global_in;
    assign wr_mcause = wr_en_in && (csr_addr_in == MCAUSE_ADDR);
    assign wr_mepc   = wr_en_in && (csr_addr_in == MEPC_ADDR);

    // Exceptions resolve to the lowest set line, interrupts to the highest.
    always_comb begin
        exc_code = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_req_in[i]) exc_code = CODE_W'(i);
        end
    end

    always_comb begin
        irq_code = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_req_in[i]) irq_code = CODE_W'(i);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (exc_any || irq_take) begin
                    capture    = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (trap_ack_in) begin
                    commit     = 1'b1;
                    state_next = HANDLER;
                end
            end
            HANDLER: begin
                // A nested exception outranks a retiring MRET in the same cycle.
                if (exc_any) begin
                    capture    = 1'b1;
                    state_next = PEND;
                end else if (mret_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            held_int  <= 1'b0;
            held_code <= '0;
            held_pc   <= '0;
        end else if (capture) begin
            held_int  <= !exc_any;
            held_code <= exc_any ? exc_code : irq_code;
            held_pc   <= pc_in & PC_MASK;
        end
    end

    always_comb begin
        trap_cause             = '0;
        trap_cause[CODE_W-1:0] = held_code;
        trap_cause[XLEN-1]     = held_int;
    end

    // A commit takes precedence over a software write to the same CSR.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mcause     <= '0;
            mepc       <= '0;
            trap_taken <= 1'b0;
        end else begin
            trap_taken <= commit;
            if (commit)         mcause <= trap_cause;
            else if (wr_mcause) mcause <= data_wr_in;
            if (commit)         mepc   <= held_pc;
            else if (wr_mepc)   mepc   <= data_wr_in & PC_MASK;
        end
    end

`ifdef MTRAP_MTVAL_EN
    logic [XLEN-1:0] held_tval;
    logic [XLEN-1:0] mtval;
    logic            wr_mtval;

    assign wr_mtval = wr_en_in && (csr_addr_in == MTVAL_ADDR);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            held_tval <= '0;
            mtval     <= '0;
        end else begin
            if (capture)       held_tval <= exc_any ? tval_in : '0;
            if (commit)        mtval     <= held_tval;
            else if (wr_mtval) mtval     <= data_wr_in;
        end
    end

    assign mtval_out = mtval;
`else
    logic unused_mtval;
    assign unused_mtval = (^tval_in) ^ (csr_addr_in == MTVAL_ADDR);
    assign mtval_out    = '0;
`endif

    always_comb begin
        csr_rd_out  = '0;
        csr_hit_out = 1'b0;
        if (csr_addr_in == MCAUSE_ADDR) begin
            csr_rd_out  = mcause;
            csr_hit_out = 1'b1;
        end else if (csr_addr_in == MEPC_ADDR) begin
            csr_rd_out  = mepc;
            csr_hit_out = 1'b1;
        end
`ifdef MTRAP_MTVAL_EN
        else if (csr_addr_in == MTVAL_ADDR) begin
            csr_rd_out  = mtval;
            csr_hit_out = 1'b1;
        end
`endif
    end

    assign mcause_out       = mcause;
    assign mepc_out         = mepc;
    assign cause_out        = mcause[CODE_W-1:0];
    assign int_or_exc_out   = mcause[XLEN-1];
    assign trap_pending_out = (state == PEND);
    assign in_handler_out   = (state == HANDLER);
    assign trap_taken_out   = trap_taken;

endmodule

// File: tb/tb_mtrap_cause_unit.sv
// Self-checking bench for mtrap_cause_unit: directed vectors, a behavioural trap model checked
// every cycle, and literal expectations for each scenario. Honours MTRAP_MTVAL_EN if defined.
module tb_mtrap_cause_unit;

`ifdef MTRAP_MTVAL_EN
    localparam bit MTVAL_EN = 1'b1;
`else
    localparam bit MTVAL_EN = 1'b0;
`endif

    localparam int M_IDLE    = 0;
    localparam int M_PEND    = 1;
    localparam int M_HANDLER = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] exc_req = '0;
    logic [15:0] irq_req = '0;
    logic        mie = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] tval = '0;
    logic        trap_ack = 1'b0;
    logic        mret = 1'b0;
    logic [11:0] csr_addr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] data_wr = '0;

    logic [31:0] csr_rd;
    logic        csr_hit;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [4:0]  cause;
    logic        int_or_exc;
    logic        trap_pending;
    logic        trap_taken;
    logic        in_handler;

    int checks   = 0;
    int failures = 0;

    mtrap_cause_unit dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .exc_req_in       (exc_req),
        .irq_req_in       (irq_req),
        .mie_global_in    (mie),
        .pc_in            (pc),
        .tval_in          (tval),
        .trap_ack_in      (trap_ack),
        .mret_in          (mret),
        .csr_addr_in      (csr_addr),
        .wr_en_in         (wr_en),
        .data_wr_in       (data_wr),
        .csr_rd_out       (csr_rd),
        .csr_hit_out      (csr_hit),
        .mcause_out       (mcause),
        .mepc_out         (mepc),
        .mtval_out        (mtval),
        .cause_out        (cause),
        .int_or_exc_out   (int_or_exc),
        .trap_pending_out (trap_pending),
        .trap_taken_out   (trap_taken),
        .in_handler_out   (in_handler)
    );

    always #5 clk = ~clk;

    // Behavioural model: trap state, held request and architectural CSRs.
    int          m_state  = M_IDLE;
    bit          m_int    = 1'b0;
    int          m_code   = 0;
    logic [31:0] m_pc     = '0;
    logic [31:0] m_tval   = '0;
    logic [31:0] m_mcause = '0;
    logic [31:0] m_mepc   = '0;
    logic [31:0] m_mtval  = '0;
    bit          m_taken  = 1'b0;

    function automatic int lowestSet(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int highestSet(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state  <= M_IDLE;
            m_int    <= 1'b0;
            m_code   <= 0;
            m_pc     <= '0;
            m_tval   <= '0;
            m_mcause <= '0;
            m_mepc   <= '0;
            m_mtval  <= '0;
            m_taken  <= 1'b0;
        end else begin
            automatic bit          commit_now = (m_state == M_PEND) && trap_ack;
            automatic int          lo         = lowestSet(exc_req);
            automatic int          hi         = highestSet(irq_req);
            automatic logic [31:0] n_mcause   = m_mcause;
            automatic logic [31:0] n_mepc     = m_mepc;
            automatic logic [31:0] n_mtval    = m_mtval;
            if (wr_en && csr_addr == 12'h342) n_mcause = data_wr;
            if (wr_en && csr_addr == 12'h341) n_mepc = {data_wr[31:2], 2'b00};
            if (wr_en && csr_addr == 12'h343 && MTVAL_EN) n_mtval = data_wr;
            if (commit_now) begin
                n_mcause = (m_int ? 32'h8000_0000 : 32'h0) + 32'(m_code);
                n_mepc   = {m_pc[31:2], 2'b00};
                n_mtval  = MTVAL_EN ? m_tval : 32'h0;
                m_state  <= M_HANDLER;
            end else if ((m_state == M_IDLE || m_state == M_HANDLER) && lo >= 0) begin
                m_int   <= 1'b0;
                m_code  <= lo;
                m_pc    <= pc;
                m_tval  <= tval;
                m_state <= M_PEND;
            end else if (m_state == M_IDLE && hi >= 0 && mie) begin
                m_int   <= 1'b1;
                m_code  <= hi;
                m_pc    <= pc;
                m_tval  <= '0;
                m_state <= M_PEND;
            end else if (m_state == M_HANDLER && mret) begin
                m_state <= M_IDLE;
            end
            m_mcause <= n_mcause;
            m_mepc   <= n_mepc;
            m_mtval  <= n_mtval;
            m_taken  <= commit_now;
        end
    end

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a)
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return MTVAL_EN ? m_mtval : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic modelHit(input logic [11:0] a);
        return (a == 12'h341) || (a == 12'h342) || (a == 12'h343 && MTVAL_EN);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge the DUT must agree with the model.
    always @(negedge clk) begin
        checkOutput("cmp_pending", 32'(trap_pending), 32'(m_state == M_PEND));
        checkOutput("cmp_handler", 32'(in_handler), 32'(m_state == M_HANDLER));
        checkOutput("cmp_taken", 32'(trap_taken), 32'(m_taken));
        checkOutput("cmp_mcause", mcause, m_mcause);
        checkOutput("cmp_cause", 32'(cause), {27'h0, m_mcause[4:0]});
        checkOutput("cmp_int", 32'(int_or_exc), 32'(m_mcause[31]));
        checkOutput("cmp_mepc", mepc, m_mepc);
        checkOutput("cmp_mtval", mtval, MTVAL_EN ? m_mtval : 32'h0);
        checkOutput("cmp_rd", csr_rd, modelRead(csr_addr));
        checkOutput("cmp_hit", 32'(csr_hit), 32'(modelHit(csr_addr)));
    end

    task automatic applyStimulus(input logic [15:0] exc, input logic [15:0] irq, input logic m,
                                 input logic ack, input logic ret, input logic [31:0] p,
                                 input logic [31:0] tv, input logic [11:0] addr,
                                 input logic we, input logic [31:0] wd);
        exc_req  = exc;
        irq_req  = irq;
        mie      = m;
        trap_ack = ack;
        mret     = ret;
        pc       = p;
        tval     = tv;
        csr_addr = addr;
        wr_en    = we;
        data_wr  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start, mtval feature = %0d", MTVAL_EN);
        #3;
        checkOutput("reset_pending", 32'(trap_pending), 32'h0);
        checkOutput("reset_mcause", mcause, 32'h0);
        checkOutput("reset_hit_addr0", 32'(csr_hit), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Exception priority over interrupts, pc alignment on mepc.
        applyStimulus(16'h0024, 16'h0880, 1, 0, 0, 32'h0000_1003, 32'hDEAD_BEEF, 12'h342, 0, 0);
        tick();
        checkOutput("exc_pending", 32'(trap_pending), 32'h1);
        checkOutput("exc_no_handler", 32'(in_handler), 32'h0);
        applyStimulus(16'h0000, 16'h0880, 1, 1, 0, 32'h0, 32'h0, 12'h342, 0, 0);
        tick();
        checkOutput("exc_taken", 32'(trap_taken), 32'h1);
        checkOutput("exc_handler", 32'(in_handler), 32'h1);
        checkOutput("exc_pending_drop", 32'(trap_pending), 32'h0);
        checkOutput("exc_mcause", mcause, 32'h0000_0002);
        checkOutput("exc_mepc", mepc, 32'h0000_1000);
        checkOutput("exc_mtval", mtval, MTVAL_EN ? 32'hDEAD_BEEF : 32'h0);
        checkOutput("exc_rd", csr_rd, 32'h0000_0002);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("exc_taken_pulse_end", 32'(trap_taken), 32'h0);
        checkOutput("exc_still_handler", 32'(in_handler), 32'h1);
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("mret_exit", 32'(in_handler), 32'h0);

        // Interrupt path: highest line wins, mtval forced to 0.
        applyStimulus(0, 16'h0888, 1, 0, 0, 32'h0000_2000, 32'h5555_5555, 12'h343, 0, 0);
        tick();
        checkOutput("irq_pending", 32'(trap_pending), 32'h1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 12'h343, 0, 0);
        tick();
        checkOutput("irq_mcause", mcause, 32'h8000_000B);
        checkOutput("irq_cause", 32'(cause), 32'h0000_000B);
        checkOutput("irq_int", 32'(int_or_exc), 32'h1);
        checkOutput("irq_mtval", mtval, 32'h0);
        checkOutput("irq_mepc", mepc, 32'h0000_2000);
        applyStimulus(0, 16'h0888, 1, 0, 1, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("irq_ignored_in_handler", 32'(trap_pending), 32'h0);

        // Masked interrupt keeps the unit idle.
        applyStimulus(0, 16'h0888, 0, 0, 0, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("irq_masked_pending", 32'(trap_pending), 32'h0);
        applyStimulus(0, 16'h0888, 0, 1, 0, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("irq_masked_handler", 32'(in_handler), 32'h0);

        // Nested exception racing MRET in the handler.
        applyStimulus(16'h0020, 0, 0, 0, 0, 32'h0000_3000, 32'h0000_0011, 12'h342, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("nest_first_mcause", mcause, 32'h0000_0005);
        applyStimulus(16'h0008, 0, 0, 0, 1, 32'h0000_4006, 32'h0000_0022, 12'h342, 0, 0);
        tick();
        checkOutput("nest_pending", 32'(trap_pending), 32'h1);
        checkOutput("nest_handler", 32'(in_handler), 32'h0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 12'h341, 0, 0);
        tick();
        checkOutput("nest_mcause", mcause, 32'h0000_0003);
        checkOutput("nest_mepc", mepc, 32'h0000_4004);
        checkOutput("nest_mtval", mtval, MTVAL_EN ? 32'h0000_0022 : 32'h0);

        // Commit beats a same-cycle software write to mcause.
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h342, 0, 0);
        tick();
        applyStimulus(16'h0080, 0, 0, 0, 0, 32'h0000_5000, 32'h0000_0033, 12'h342, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h342, 1, 32'h1234_5678);
        tick();
        checkOutput("conflict_mcause", mcause, 32'h0000_0007);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h341, 1, 32'hFFFF_FFFF);
        tick();
        checkOutput("sw_mepc", mepc, 32'hFFFF_FFFC);
        checkOutput("sw_mepc_rd", csr_rd, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h342, 1, 32'h8000_0003);
        tick();
        checkOutput("sw_mcause", mcause, 32'h8000_0003);
        checkOutput("sw_mcause_int", 32'(int_or_exc), 32'h1);

        // Asynchronous reset while a trap is pending.
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h342, 0, 0);
        tick();
        applyStimulus(16'h0004, 0, 0, 0, 0, 32'h0000_6000, 32'h0000_0044, 12'h342, 0, 0);
        tick();
        checkOutput("rst_pre_pending", 32'(trap_pending), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h342, 0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_pending", 32'(trap_pending), 32'h0);
        checkOutput("rst_async_handler", 32'(in_handler), 32'h0);
        checkOutput("rst_async_mcause", mcause, 32'h0);
        checkOutput("rst_async_mepc", mepc, 32'h0);
        checkOutput("rst_async_rd", csr_rd, 32'h0);
        checkOutput("rst_async_hit", 32'(csr_hit), 32'h1);
        #2 rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h342, 0, 0);
        tick();
        checkOutput("late_ack_taken", 32'(trap_taken), 32'h0);
        checkOutput("late_ack_handler", 32'(in_handler), 32'h0);
        checkOutput("late_ack_mcause", mcause, 32'h0);

        // mtval address decode and capture follow the build option.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h343, 1, 32'hAAAA_5555);
        tick();
        checkOutput("mtval_hit", 32'(csr_hit), 32'(MTVAL_EN));
        checkOutput("mtval_rd", csr_rd, MTVAL_EN ? 32'hAAAA_5555 : 32'h0);
        applyStimulus(16'h0002, 0, 0, 0, 0, 32'h0000_7000, 32'hCAFE_F00D, 12'h343, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h343, 0, 0);
        tick();
        checkOutput("mtval_after_exc", mtval, MTVAL_EN ? 32'hCAFE_F00D : 32'h0);
        checkOutput("mtval_mcause", mcause, 32'h0000_0001);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 0, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
